// File: rtl/stream_cipher_pkg.sv
// rtl/stream_cipher_pkg.sv - shared stream-cipher types
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } interface_state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READY = 2'd1,
    FULL  = 2'd2
  } output_queue_state_t;

endpackage

// File: rtl/output_queue.sv
// rtl/output_queue.sv - circular result queue between encryption block and interface FSM
module output_queue
  import stream_cipher_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter bit FLUSH_ON_IDLE = 1'b1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_in_pulse,
  input  logic                       rd_ack,
  input  interface_state_t           interface_state,
  output output_queue_state_t        queue_state_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic          flush, is_full, is_empty, do_pop, do_push;
  logic [PW-1:0] wr_addr;

  assign flush    = FLUSH_ON_IDLE && (interface_state == IDLE);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign do_pop   = rd_ack && !is_empty && !flush;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_push  = data_in_pulse && (flush || !is_full || do_pop);
  assign wr_addr  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_addr] <= data_in;
      if (flush) begin
        rd_ptr     <= '0;
        wr_ptr     <= do_push ? PW'(1) : '0;
        count_q    <= do_push ? CW'(1) : '0;
        overflow_q <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (do_push && !do_pop)      count_q <= count_q + CW'(1);
        else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        if (data_in_pulse && !do_push) overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    queue_state_out = READY;
    if (is_empty)     queue_state_out = EMPTY;
    else if (is_full) queue_state_out = FULL;
  end

  assign data_out = is_empty ? '0 : mem[rd_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_output_queue.sv
// tb/tb_output_queue.sv - directed self-checking bench for output_queue
module tb_output_queue;
  import stream_cipher_pkg::*;

  logic                clk = 1'b0;
  logic                nrst;
  logic [7:0]          data_in;
  logic                data_in_pulse;
  logic                rd_ack;
  interface_state_t    interface_state;
  output_queue_state_t queue_state_out, nf_state;
  logic [7:0]          data_out, nf_data;
  logic [2:0]          count, nf_count;
  logic                overflow, nf_overflow;

  int checks = 0;
  int errors = 0;

  output_queue #(.WIDTH(8), .DEPTH(4), .FLUSH_ON_IDLE(1'b1)) dut (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_in_pulse(data_in_pulse),
    .rd_ack(rd_ack), .interface_state(interface_state),
    .queue_state_out(queue_state_out), .data_out(data_out),
    .count(count), .overflow(overflow)
  );

  output_queue #(.WIDTH(8), .DEPTH(4), .FLUSH_ON_IDLE(1'b0)) dut_nf (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_in_pulse(data_in_pulse),
    .rd_ack(rd_ack), .interface_state(interface_state),
    .queue_state_out(nf_state), .data_out(nf_data),
    .count(nf_count), .overflow(nf_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    data_in_pulse = 1'b0;
    rd_ack        = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    data_in       = d;
    data_in_pulse = 1'b1;
    step();
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    step();
  endtask

  task automatic expect_q(input string tag, input logic [7:0] d, input logic [2:0] c,
                          input output_queue_state_t s);
    check({tag, ".data"},  32'(data_out), 32'(d));
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".state"}, 32'(queue_state_out), 32'(s));
  endtask

  initial begin
    nrst = 1'b0; data_in = '0; data_in_pulse = 1'b0; rd_ack = 1'b0;
    interface_state = LOAD;
    #12 nrst = 1'b1;
    #1;
    expect_q("reset", 8'h00, 3'd0, EMPTY);
    check("reset.ovf", 32'(overflow), 32'd0);

    // in-order delivery, one-cycle latency
    push(8'h11);
    expect_q("p1", 8'h11, 3'd1, READY);
    push(8'h22);
    push(8'h33);
    expect_q("p3", 8'h11, 3'd3, READY);
    ack(); expect_q("a1", 8'h22, 3'd2, READY);
    ack(); expect_q("a2", 8'h33, 3'd1, READY);
    ack(); expect_q("a3", 8'h00, 3'd0, EMPTY);

    // overflow while full
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    expect_q("fill", 8'hA0, 3'd4, FULL);
    check("fill.ovf", 32'(overflow), 32'd0);
    push(8'hA4);
    expect_q("drop", 8'hA0, 3'd4, FULL);
    check("drop.ovf", 32'(overflow), 32'd1);
    for (int i = 1; i < 4; i++) begin
      ack();
      check($sformatf("drain%0d", i), 32'(data_out), 32'(8'hA0 + 8'(i)));
    end
    ack();
    expect_q("drained", 8'h00, 3'd0, EMPTY);

    // idle clears overflow only when flush is enabled
    interface_state = IDLE;
    step();
    interface_state = LOAD;
    check("idle.ovf", 32'(overflow), 32'd0);
    check("nf.idle.ovf", 32'(nf_overflow), 32'd1);

    // push and pop together while full
    for (int i = 1; i <= 4; i++) push(8'(i));
    data_in = 8'h55; data_in_pulse = 1'b1; rd_ack = 1'b1;
    step();
    expect_q("pp_full", 8'h02, 3'd4, FULL);
    check("pp_full.ovf", 32'(overflow), 32'd0);
    ack(); check("pp.o3", 32'(data_out), 32'h03);
    ack(); check("pp.o4", 32'(data_out), 32'h04);
    ack(); check("pp.o55", 32'(data_out), 32'h55);
    ack(); expect_q("pp.empty", 8'h00, 3'd0, EMPTY);

    // alternate push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(8'h60 + 8'(i));
      check($sformatf("alt%0d", i), 32'(data_out), 32'(8'h60 + 8'(i)));
      ack();
      check($sformatf("alt%0d.cnt", i), 32'(count), 32'd0);
    end
    ack();
    expect_q("ack_empty", 8'h00, 3'd0, EMPTY);

    // push while empty with simultaneous ack: push only
    data_in = 8'h42; data_in_pulse = 1'b1; rd_ack = 1'b1;
    step();
    expect_q("pp_empty", 8'h42, 3'd1, READY);
    ack();

    // flush with concurrent pulse and ack
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    ack();
    expect_q("hold3", 8'hC1, 3'd3, READY);
    check("hold3.ovf", 32'(overflow), 32'd1);
    interface_state = IDLE; data_in = 8'h7E; data_in_pulse = 1'b1; rd_ack = 1'b1;
    step();
    interface_state = LOAD;
    expect_q("flush", 8'h7E, 3'd1, READY);
    check("flush.ovf", 32'(overflow), 32'd0);
    check("nf.flush.ovf", 32'(nf_overflow), 32'd1);
    ack();

    // asynchronous reset mid-cycle
    push(8'hD1);
    push(8'hD2);
    expect_q("pre_rst", 8'hD1, 3'd2, READY);
    #2 nrst = 1'b0;
    #1;
    expect_q("async_rst", 8'h00, 3'd0, EMPTY);
    check("async_rst.ovf", 32'(nf_overflow), 32'd0);
    #10 nrst = 1'b1;
    push(8'h99);
    expect_q("post_rst", 8'h99, 3'd1, READY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
